pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised successor PC generator for the V-FRONT core.
- Holds the fetch PC and selects the next PC by fixed priority: reset, trap, trap-return, jump / taken branch, stall, sequential.
- Adds a stall hold, a trap/return path with a saved EPC, and a halt/resume state machine.
- Sits between the execute stage (ALU/comparator) and instruction memory.

Parameters:
- OPD_WIDTH, 32, operand/datapath width of alu_result, comp_result and pc_plus4.
- PC_WIDTH, 12, width of the PC register and instruction address.
- RESET_VECTOR, 0, PC value loaded on reset (PC_WIDTH bits).
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on posedge only.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (pipeline stall).
- branch  in  1  conditional branch in execute.
- jump  in  1  unconditional jump (JAL/JALR).
- comp_result  in  OPD_WIDTH  comparator result; branch taken iff value == 1.
- alu_result  in  OPD_WIDTH  jump/branch target address.
- trap  in  1  exception/interrupt request.
- trap_vector  in  PC_WIDTH  trap handler address.
- mret  in  1  return from trap.
- halt_req  in  1  debug halt request.
- resume  in  1  leave halt.
- pc  out  PC_WIDTH  current fetch address.
- pc_plus4  out  OPD_WIDTH  pc + PC_INC, zero-extended (link value).
- pc_valid  out  1  pc is a valid fetch address this cycle.
- epc  out  PC_WIDTH  PC saved at the last trap.
- halted  out  1  high while in S_HALT.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+PC_INC, epc=0, state=S_RESET.
  - pc_valid=0, halted=0.
  - Reset overrides every other input, including mid-trap or mid-halt.
- States:
  - S_RESET: pc_valid=0; always moves to S_RUN on the next posedge; pc unchanged.
  - S_RUN: pc_valid=1 except while stall=1, where pc_valid stays 1 and pc holds.
  - S_HALT: pc_valid=0, halted=1, pc and epc held. Trap, mret, jump and branch are ignored. resume=1 returns to S_RUN with pc unchanged.
- Next-PC priority in S_RUN, highest first:
  1. trap: pc<=trap_vector, epc<=pc.
  2. mret: pc<=epc.
  3. jump, or branch with comp_result==1: pc<=alu_result[PC_WIDTH-1:0] with bit0 forced to 0.
  4. stall: pc held.
  5. Otherwise: pc<=pc+PC_INC.
- Redirects (trap, mret, jump, taken branch) override stall in the same cycle.
- halt_req in S_RUN:
  - With no redirect in that cycle: pc holds and the state becomes S_HALT at the next posedge.
  - With a redirect in that cycle: the redirect is applied first, and S_HALT is entered on the following cycle if halt_req is still high.
- Arithmetic:
  - pc+PC_INC wraps modulo 2^PC_WIDTH (max address+PC_INC -> low address).
  - pc_plus4 always tracks the registered pc, updated in the same posedge.
  - Upper alu_result bits beyond PC_WIDTH are discarded.
- Latency: one cycle from redirect input to new pc; no combinational input-to-pc path.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - A jump/taken-branch target with bit1 set (after bit0 clear) is not taken: pc<=trap_vector, epc<=pc, and misalign pulses high for one cycle.
  - Port trap still has higher priority.
- Undefined:
  - No port.
  - Bit1 is passed through unchanged.

Decomposition:
- common_library.vh: state encodings S_RESET/S_RUN/S_HALT (2-bit localparams) and next-PC select codes (SEL_TRAP, SEL_MRET, SEL_TGT, SEL_HOLD, SEL_SEQ).
- Sub-module pc_next_sel: combinational priority encoder producing the select code and target. The top holds the registers and FSM.

Test Plan:
1. rst 1 cycle, then run 3 cycles -> pc 0 (pc_valid=0), then 0, 4, 8; pc_plus4 = 4, 4, 8, 12.
2. At pc=0x010: jump=1, alu_result=0x00000123 -> next pc=0x122. Then branch=1, comp_result=0 -> pc=0x126.
3. pc=0xFFC with PC_WIDTH=12, no redirect -> pc wraps to 0x000, pc_plus4=0x004.
4. pc=0x040 with trap=1, jump=1, stall=1, trap_vector=0x200 -> pc=0x200, epc=0x040. Later mret=1 -> pc=0x040.
5. halt_req=1 at pc=0x080 -> halted=1, pc_valid=0, pc stays 0x080 while jump=1 is applied. Then resume=1 -> pc_valid=1 and pc resumes 0x080, 0x084.
6. With PC_MISALIGN_TRAP_EN: jump to 0x102 with trap_vector=0x300 -> pc=0x300, misalign=1 for one cycle. Without the macro -> pc=0x102.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the pc_sequencer block: FSM states and next-PC select codes.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_TRAP = 3'd0,
        SEL_MRET = 3'd1,
        SEL_TGT  = 3'd2,
        SEL_HOLD = 3'd3,
        SEL_SEQ  = 3'd4
    } sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder: trap > mret > jump/taken branch > hold > sequential.
// With PC_MISALIGN_TRAP_EN defined, a target with bit1 set is turned into a trap.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int OPD_WIDTH = 32,
    parameter int PC_WIDTH  = 12
) (
    input  logic                 i_stall,
    input  logic                 i_branch,
    input  logic                 i_jump,
    input  logic [OPD_WIDTH-1:0] i_comp_result,
    input  logic [OPD_WIDTH-1:0] i_alu_result,
    input  logic                 i_trap,
    input  logic                 i_mret,
    input  logic                 i_halt_req,
    output sel_e                 o_sel,
    output logic [PC_WIDTH-1:0]  o_target,
    output logic                 o_redirect,
    output logic                 o_misalign
);

    logic w_taken;
    logic w_unused;

    assign w_taken  = i_jump | (i_branch & (i_comp_result == OPD_WIDTH'(1)));
    assign o_target = {i_alu_result[PC_WIDTH-1:1], 1'b0};
    // Target bit0 and address bits above the PC are deliberately dropped.
    assign w_unused = ^{i_alu_result[OPD_WIDTH-1:PC_WIDTH], i_alu_result[0]};

    always_comb begin
        o_sel      = SEL_SEQ;
        o_redirect = 1'b1;
        o_misalign = 1'b0;
        if (i_trap) begin
            o_sel = SEL_TRAP;
        end else if (i_mret) begin
            o_sel = SEL_MRET;
        end else if (w_taken) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (o_target[1]) begin
                o_sel      = SEL_TRAP;
                o_misalign = 1'b1;
            end else begin
                o_sel = SEL_TGT;
            end
`else
            o_sel = SEL_TGT;
`endif
        end else begin
            o_redirect = 1'b0;
            // A pending halt freezes the PC exactly like a stall.
            if (i_stall || i_halt_req) begin
                o_sel = SEL_HOLD;
            end else begin
                o_sel = SEL_SEQ;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with trap/return (saved EPC) and a halt/resume FSM.
// Optional macro PC_MISALIGN_TRAP_EN adds the misalign output and misaligned-target trapping.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                   OPD_WIDTH    = 32,
    parameter int                   PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                   PC_INC       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 jump,
    input  logic [OPD_WIDTH-1:0] comp_result,
    input  logic [OPD_WIDTH-1:0] alu_result,
    input  logic                 trap,
    input  logic [PC_WIDTH-1:0]  trap_vector,
    input  logic                 mret,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [OPD_WIDTH-1:0] pc_plus4,
    output logic                 pc_valid,
    output logic [PC_WIDTH-1:0]  epc,
    output logic                 halted
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic                 misalign
`endif
);

    localparam logic [PC_WIDTH-1:0] PC_INC_W = PC_WIDTH'(PC_INC);
    localparam logic [PC_WIDTH-1:0] RESET_PLUS = RESET_VECTOR + PC_INC_W;

    state_e                r_state;
    state_e                w_state_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic [PC_WIDTH-1:0]   w_pc_next_inc;
    logic [OPD_WIDTH-1:0]  r_pc_plus4;
    logic [PC_WIDTH-1:0]   r_epc;
    logic [PC_WIDTH-1:0]   w_epc_next;
    logic                  r_misalign;
    logic                  w_misalign_next;

    sel_e                  w_sel;
    logic [PC_WIDTH-1:0]   w_target;
    logic                  w_redirect;
    logic                  w_misalign_hit;

    pc_next_sel #(
        .OPD_WIDTH (OPD_WIDTH),
        .PC_WIDTH  (PC_WIDTH)
    ) u_next_sel (
        .i_stall       (stall),
        .i_branch      (branch),
        .i_jump        (jump),
        .i_comp_result (comp_result),
        .i_alu_result  (alu_result),
        .i_trap        (trap),
        .i_mret        (mret),
        .i_halt_req    (halt_req),
        .o_sel         (w_sel),
        .o_target      (w_target),
        .o_redirect    (w_redirect),
        .o_misalign    (w_misalign_hit)
    );

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_epc_next      = r_epc;
        w_misalign_next = 1'b0;
        case (r_state)
            S_RESET: w_state_next = S_RUN;
            S_RUN: begin
                case (w_sel)
                    SEL_TRAP: begin
                        w_pc_next  = trap_vector;
                        w_epc_next = r_pc;
                    end
                    SEL_MRET: w_pc_next = r_epc;
                    SEL_TGT:  w_pc_next = w_target;
                    SEL_HOLD: w_pc_next = r_pc;
                    default:  w_pc_next = r_pc + PC_INC_W;
                endcase
                w_misalign_next = w_misalign_hit;
                // A redirect wins the cycle; halt is taken later if still requested.
                if (halt_req && !w_redirect) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_RESET;
        endcase
    end

    assign w_pc_next_inc = w_pc_next + PC_INC_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_VECTOR;
            r_pc_plus4 <= {{(OPD_WIDTH-PC_WIDTH){1'b0}}, RESET_PLUS};
            r_epc      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pc_plus4 <= {{(OPD_WIDTH-PC_WIDTH){1'b0}}, w_pc_next_inc};
            r_epc      <= w_epc_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = r_pc_plus4;
    assign epc      = r_epc;
    assign pc_valid = (r_state == S_RUN);
    assign halted   = (r_state == S_HALT);

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = r_misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = r_misalign;
`endif

endmodule
